// File: rtl/div_unit_pkg.sv
// Shared constants and helpers for the iterative restoring divider.
package div_unit_pkg;

    // Operand width and number of restoring steps (one quotient bit per step)
    localparam int DIV_W     = 32;
    localparam int DIV_STEPS = 32;
    localparam int CNT_W     = 5;

    // Control-state encoding of the divider sequencer
    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    // Handshake levels used on the EX interface
    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

    // Index of the last restoring step
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DIV_STEPS - 1);

    // 32-bit two's complement negation (wraps modulo 2^32)
    function automatic logic [DIV_W-1:0] neg32(input logic [DIV_W-1:0] v);
        return (~v) + {{(DIV_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/div_unit.sv
// Iterative restoring 32-bit divider; returns {remainder, quotient} after 32 steps.
module div_unit
    import div_unit_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signed_div_i,
    input  logic [DIV_W-1:0]     opdata1_i,
    input  logic [DIV_W-1:0]     opdata2_i,
    input  logic                 start_i,
    input  logic                 annul_i,
    output logic [2*DIV_W-1:0]   result_o,
    output logic                 ready_o
);

    div_state_e             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [2*DIV_W:0]       w_q, w_d;          // 65-bit working register
    logic [DIV_W-1:0]       divisor_q, divisor_d;
    logic                   qsign_q, qsign_d;
    logic                   rsign_q, rsign_d;
    logic [2*DIV_W-1:0]     result_q, result_d;
    logic                   ready_q, ready_d;

    // Datapath helpers: operand magnitudes and one restoring step
    logic [DIV_W-1:0]       op1_mag;
    logic [DIV_W-1:0]       op2_mag;
    logic [DIV_W:0]         diff;
    logic [2*DIV_W:0]       step_w;
    logic [DIV_W-1:0]       quo_mag;
    logic [DIV_W-1:0]       rem_mag;

    // Negative operands are divided as magnitudes; signs are re-applied at the end
    always_comb begin
        op1_mag = opdata1_i;
        op2_mag = opdata2_i;
        if (signed_div_i && opdata1_i[DIV_W-1]) begin
            op1_mag = neg32(opdata1_i);
        end
        if (signed_div_i && opdata2_i[DIV_W-1]) begin
            op2_mag = neg32(opdata2_i);
        end
    end

    // One restoring step: trial-subtract the divisor from the partial-remainder window
    always_comb begin
        diff = w_q[2*DIV_W:DIV_W] - {1'b0, divisor_q};
        if (diff[DIV_W]) begin
            // Trial went negative: keep the remainder, shift in quotient bit 0
            step_w = {w_q[2*DIV_W-1:0], 1'b0};
        end else begin
            // Trial fits: replace the remainder with the difference, quotient bit 1
            step_w = {diff[DIV_W-1:0], w_q[DIV_W-1:0], 1'b1};
        end
        // Final results are taken from the register as it will be after this step
        quo_mag = step_w[DIV_W-1:0];
        rem_mag = step_w[2*DIV_W:DIV_W+1];
    end

    // Next-state and output logic of the divider sequencer
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        w_d       = w_q;
        divisor_d = divisor_q;
        qsign_d   = qsign_q;
        rsign_d   = rsign_q;
        result_d  = result_q;
        ready_d   = ready_q;

        case (state_q)
            DivFree: begin
                result_d = '0;
                ready_d  = DivResultNotReady;
                if (start_i == DivStart && !annul_i) begin
                    if (opdata2_i == '0) begin
                        state_d = DivByZero;
                    end else begin
                        state_d   = DivOn;
                        cnt_d     = '0;
                        w_d       = {{DIV_W{1'b0}}, op1_mag, 1'b0};
                        divisor_d = op2_mag;
                        qsign_d   = signed_div_i & (opdata1_i[DIV_W-1] ^ opdata2_i[DIV_W-1]);
                        rsign_d   = signed_div_i & opdata1_i[DIV_W-1];
                    end
                end
            end

            DivByZero: begin
                result_d = '0;
                if (annul_i) begin
                    state_d = DivFree;
                    ready_d = DivResultNotReady;
                end else begin
                    state_d = DivEnd;
                    ready_d = DivResultReady;
                end
            end

            DivOn: begin
                if (annul_i) begin
                    state_d  = DivFree;
                    result_d = '0;
                    ready_d  = DivResultNotReady;
                end else begin
                    w_d   = step_w;
                    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (cnt_q == LAST_STEP) begin
                        state_d  = DivEnd;
                        result_d = {(rsign_q ? neg32(rem_mag) : rem_mag),
                                    (qsign_q ? neg32(quo_mag) : quo_mag)};
                        ready_d  = DivResultReady;
                    end
                end
            end

            DivEnd: begin
                // Hold the result until EX releases the request; annul has no effect here
                if (start_i == DivStop) begin
                    state_d  = DivFree;
                    result_d = '0;
                    ready_d  = DivResultNotReady;
                end
            end

            default: begin
                state_d  = DivFree;
                result_d = '0;
                ready_d  = DivResultNotReady;
            end
        endcase
    end

    // State, datapath and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= DivFree;
            cnt_q     <= '0;
            w_q       <= '0;
            divisor_q <= '0;
            qsign_q   <= 1'b0;
            rsign_q   <= 1'b0;
            result_q  <= '0;
            ready_q   <= DivResultNotReady;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            w_q       <= w_d;
            divisor_q <= divisor_d;
            qsign_q   <= qsign_d;
            rsign_q   <= rsign_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: expected results queued at issue, compared at ready.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int total = 0;
    int bad   = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    div_unit dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, exp);
        end
    endtask

    // Reference: truncating division on magnitudes, signs applied afterwards
    function automatic logic [63:0] model(input bit sg, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ma, mb, q, r;
        if (b == 32'd0) return 64'd0;
        ma = (sg && a[31]) ? (~a + 32'd1) : a;
        mb = (sg && b[31]) ? (~b + 32'd1) : b;
        q  = ma / mb;
        r  = ma % mb;
        if (sg && (a[31] ^ b[31])) q = ~q + 32'd1;
        if (sg && a[31])           r = ~r + 32'd1;
        return {r, q};
    endfunction

    // Drive a request at a falling edge; the next rising edge is the acceptance edge
    task automatic drive_op(input bit sg, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        signed_div_i = sg;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
    endtask

    task automatic issue(input bit sg, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] e);
        drive_op(sg, a, b);
        exp_q.push_back(e);
    endtask

    // Wait for ready (bounded), check latency and result, optionally hold, then release
    task automatic collect(input string tag, input int lat_exp, input int hold, input bit release_req);
        int cycles;
        logic [63:0] e;
        cycles = 0;
        do begin
            @(posedge clk);
            @(negedge clk);
            cycles++;
        end while (!ready_o && cycles < 100);
        chk({tag, "_ready"}, {63'd0, ready_o}, 64'd1);
        chk({tag, "_lat"}, 64'(cycles - 1), 64'(lat_exp));
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
        chk({tag, "_res"}, result_o, e);
        $display("txn %s: sg=%0d a=%h b=%h result=%h want=%h lat=%0d",
                 tag, signed_div_i, opdata1_i, opdata2_i, result_o, e, cycles - 1);
        // Changing operands while holding must not restart or alter the result
        for (int i = 0; i < hold; i++) begin
            opdata1_i = $urandom;
            opdata2_i = $urandom;
            @(negedge clk);
            chk({tag, "_hold_res"}, result_o, e);
            chk({tag, "_hold_rdy"}, {63'd0, ready_o}, 64'd1);
        end
        if (release_req) begin
            start_i = 1'b0;
            @(negedge clk);
            chk({tag, "_rel_rdy"}, {63'd0, ready_o}, 64'd0);
            chk({tag, "_rel_res"}, result_o, 64'd0);
        end
    endtask

    initial begin
        int seen;
        logic [31:0] ra, rb;
        bit rs;

        rst          = 1'b1;
        signed_div_i = 1'b0;
        opdata1_i    = '0;
        opdata2_i    = '0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_rdy", {63'd0, ready_o}, 64'd0);
        chk("reset_res", result_o, 64'd0);
        rst = 1'b0;

        // Directed cases with hand-computed {HI, LO}
        issue(1'b0, 32'd100, 32'd7, {32'd2, 32'd14});
        collect("divu_100_7", 32, 0, 1'b1);
        issue(1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        collect("div_m7_2", 32, 0, 1'b1);
        issue(1'b1, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD});
        collect("div_7_m2", 32, 0, 1'b1);
        issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000});
        collect("div_ovf", 32, 0, 1'b1);
        issue(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'd0});
        collect("divu_ovf", 32, 0, 1'b1);
        issue(1'b0, 32'd1234, 32'd0, 64'd0);
        collect("div_zero", 1, 0, 1'b1);
        issue(1'b0, 32'hFFFF_FFFF, 32'd1, {32'd0, 32'hFFFF_FFFF});
        collect("divu_max_1", 32, 0, 1'b1);

        // Hold start high after ready: stable result, no restart
        issue(1'b0, 32'd1000, 32'd3, {32'd1, 32'd333});
        collect("hold", 32, 5, 1'b1);

        // Annul at step 10: must never complete
        drive_op(1'b0, 32'd100, 32'd7);
        @(posedge clk);
        repeat (10) @(posedge clk);
        @(negedge clk);
        annul_i = 1'b1;
        start_i = 1'b0;
        @(negedge clk);
        annul_i = 1'b0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (ready_o) seen = 1;
        end
        chk("annul_never_ready", 64'(seen), 64'd0);
        chk("annul_res", result_o, 64'd0);
        issue(1'b0, 32'd100, 32'd7, {32'd2, 32'd14});
        collect("after_annul", 32, 0, 1'b1);

        // Annul while free blocks acceptance; releasing it lets the held request in
        @(negedge clk);
        signed_div_i = 1'b1;
        opdata1_i    = 32'hFFFF_FF9C;
        opdata2_i    = 32'd7;
        start_i      = 1'b1;
        annul_i      = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (ready_o) seen = 1;
        end
        chk("annul_free_block", 64'(seen), 64'd0);
        annul_i = 1'b0;
        exp_q.push_back({32'hFFFF_FFFE, 32'hFFFF_FFF2});
        collect("after_free_annul", 32, 0, 1'b1);

        // Reset at step 20, then a normal operation
        drive_op(1'b0, 32'd100, 32'd7);
        @(posedge clk);
        repeat (20) @(posedge clk);
        @(negedge clk);
        rst     = 1'b1;
        start_i = 1'b0;
        @(negedge clk);
        chk("rst_mid_rdy", {63'd0, ready_o}, 64'd0);
        chk("rst_mid_res", result_o, 64'd0);
        rst = 1'b0;
        issue(1'b1, 32'd100, 32'hFFFF_FFF9, {32'd2, 32'hFFFF_FFF2});
        collect("after_rst", 32, 0, 1'b0);

        // Reset while holding a finished result clears the outputs
        rst     = 1'b1;
        start_i = 1'b0;
        @(negedge clk);
        chk("rst_end_rdy", {63'd0, ready_o}, 64'd0);
        chk("rst_end_res", result_o, 64'd0);
        rst = 1'b0;

        // Random traffic through the scoreboard
        for (int n = 0; n < 10; n++) begin
            rs = 1'($urandom_range(0, 1));
            ra = $urandom;
            rb = (n % 3 == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            if (n % 4 == 1) rb = rb >> $urandom_range(0, 31);
            issue(rs, ra, rb, model(rs, ra, rb));
            collect("rand", (rb == 32'd0) ? 1 : 32, 0, 1'b1);
        end

        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
